// File: rtl/uart_cmd_assembler.sv
// Pairs UART bytes (high first) into 16-bit commands and forwards response bytes to the transmitter.
// Optional partial-command timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        resp_send,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        timeout_err
);

  typedef enum logic {IDLE, HIGH} state_t;

  state_t     state;
  logic [7:0] hi_byte;
  logic       acc;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned      CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]    TLAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] tcnt;
`endif

  // Masking with our own pulse stops a second capture while the receiver's rdy is still falling.
  assign acc = rx_rdy & ~clr_rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hi_byte     <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      tx_data     <= '0;
      trmt        <= 1'b0;
      resp_busy   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tcnt        <= '0;
`endif
    end else begin
      clr_rx_rdy  <= 1'b0;
      trmt        <= 1'b0;
      timeout_err <= 1'b0;

      // Clear first so a completing low byte below overrides it.
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (acc) begin
            hi_byte    <= rx_data;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b1;
            state      <= HIGH;
`ifdef UART_CMD_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end
        HIGH: begin
          if (acc) begin
            cmd        <= {hi_byte, rx_data};
            cmd_rdy    <= 1'b1;
            clr_rx_rdy <= 1'b1;
            state      <= IDLE;
          end
`ifdef UART_CMD_TIMEOUT_EN
          else if (tcnt == TLAST) begin
            hi_byte     <= '0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase

      if (resp_send && !resp_busy) begin
        tx_data   <= resp;
        trmt      <= 1'b1;
        resp_busy <= 1'b1;
      end else if (resp_busy && tx_done) begin
        resp_busy <= 1'b0;
      end
    end
  end

endmodule
